// File: rtl/paint_scheduler.sv
// paint_scheduler
//   Frame-level sequencer in front of one paint_element instance. A frame
//   request optionally sweeps the whole frame with CLEAR_PALETTE. It then
//   walks the sprite table in index order and runs paint_element once per
//   valid, non-empty entry. The resulting pixels are forwarded to the
//   frame-RAM write port, with palette 0 treated as transparent.
//
//   Optional feature macro: PAINT_SCHEDULER_CLEAR_EN (clear pass present when
//   defined; without it IDLE goes straight to SCAN).
//
// Ports
//   clk_33m, rst            : clock, synchronous active-high reset
//   frame_start             : one-cycle frame request (honoured in IDLE only)
//   busy, frame_done        : not-idle flag, one-cycle completion pulse
//   elem_we/elem_idx/elem_* : sprite table write port
//   paint_rst, paint_*      : start pulse and latched element parameters
//   paint_finished,
//   paint_write_*           : status and pixel stream from paint_element
//   out_we/out_x/out_y/
//   out_palette             : frame-RAM write port
module paint_scheduler #(
    parameter int         COOR_WIDTH    = 12,
    parameter int         MAX_ELEMENTS  = 16,
    parameter int         FRAME_WIDTH   = 1280,
    parameter int         FRAME_HEIGHT  = 300,
    parameter logic [2:0] CLEAR_PALETTE = 3'd1
) (
    input  logic                                clk_33m,
    input  logic                                rst,
    input  logic                                frame_start,
    output logic                                busy,
    output logic                                frame_done,
    input  logic                                elem_we,
    input  logic [$clog2(MAX_ELEMENTS)-1:0]     elem_idx,
    input  logic                                elem_valid,
    input  logic [COOR_WIDTH-1:0]               elem_sprite_x,
    input  logic [COOR_WIDTH-1:0]               elem_sprite_y,
    input  logic signed [COOR_WIDTH-1:0]        elem_frame_x,
    input  logic signed [COOR_WIDTH-1:0]        elem_frame_y,
    input  logic [COOR_WIDTH-1:0]               elem_width,
    input  logic [COOR_WIDTH-1:0]               elem_height,
    output logic                                paint_rst,
    output logic [COOR_WIDTH-1:0]               paint_sprite_x,
    output logic [COOR_WIDTH-1:0]               paint_sprite_y,
    output logic signed [COOR_WIDTH-1:0]        paint_frame_x,
    output logic signed [COOR_WIDTH-1:0]        paint_frame_y,
    output logic [COOR_WIDTH-1:0]               paint_width,
    output logic [COOR_WIDTH-1:0]               paint_height,
    input  logic                                paint_finished,
    input  logic [COOR_WIDTH-1:0]               paint_write_x,
    input  logic [COOR_WIDTH-1:0]               paint_write_y,
    input  logic [2:0]                          paint_write_palette,
    output logic                                out_we,
    output logic [COOR_WIDTH-1:0]               out_x,
    output logic [COOR_WIDTH-1:0]               out_y,
    output logic [2:0]                          out_palette
);

    localparam int IDX_W = $clog2(MAX_ELEMENTS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_ELEMENTS - 1);

`ifdef PAINT_SCHEDULER_CLEAR_EN
    localparam logic [COOR_WIDTH-1:0] LAST_X = COOR_WIDTH'(FRAME_WIDTH - 1);
    localparam logic [COOR_WIDTH-1:0] LAST_Y = COOR_WIDTH'(FRAME_HEIGHT - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_CLEAR, ST_SCAN, ST_ISSUE, ST_WAIT, ST_DONE
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE, ST_SCAN, ST_ISSUE, ST_WAIT, ST_DONE
    } state_t;
`endif

    // Frame geometry and clear colour only matter to the clear pass.
    logic cfg_unused;
    assign cfg_unused = ^{CLEAR_PALETTE, 32'(FRAME_WIDTH), 32'(FRAME_HEIGHT)};

    // Sprite table; only the valid bits are reset.
    logic [MAX_ELEMENTS-1:0]      tbl_valid_q, tbl_valid_d;
    logic [COOR_WIDTH-1:0]        tbl_sx_q [MAX_ELEMENTS];
    logic [COOR_WIDTH-1:0]        tbl_sx_d [MAX_ELEMENTS];
    logic [COOR_WIDTH-1:0]        tbl_sy_q [MAX_ELEMENTS];
    logic [COOR_WIDTH-1:0]        tbl_sy_d [MAX_ELEMENTS];
    logic signed [COOR_WIDTH-1:0] tbl_fx_q [MAX_ELEMENTS];
    logic signed [COOR_WIDTH-1:0] tbl_fx_d [MAX_ELEMENTS];
    logic signed [COOR_WIDTH-1:0] tbl_fy_q [MAX_ELEMENTS];
    logic signed [COOR_WIDTH-1:0] tbl_fy_d [MAX_ELEMENTS];
    logic [COOR_WIDTH-1:0]        tbl_w_q  [MAX_ELEMENTS];
    logic [COOR_WIDTH-1:0]        tbl_w_d  [MAX_ELEMENTS];
    logic [COOR_WIDTH-1:0]        tbl_h_q  [MAX_ELEMENTS];
    logic [COOR_WIDTH-1:0]        tbl_h_d  [MAX_ELEMENTS];

    state_t                       state_q, state_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [1:0]                   fill_q, fill_d;
    logic [COOR_WIDTH-1:0]        psx_q, psx_d, psy_q, psy_d;
    logic signed [COOR_WIDTH-1:0] pfx_q, pfx_d, pfy_q, pfy_d;
    logic [COOR_WIDTH-1:0]        pw_q, pw_d, ph_q, ph_d;
`ifdef PAINT_SCHEDULER_CLEAR_EN
    logic [COOR_WIDTH-1:0]        clr_x_q, clr_x_d, clr_y_q, clr_y_d;
`endif

    // Table write port: elem_idx wraps naturally through its width.
    always_comb begin
        tbl_valid_d = tbl_valid_q;
        tbl_sx_d    = tbl_sx_q;
        tbl_sy_d    = tbl_sy_q;
        tbl_fx_d    = tbl_fx_q;
        tbl_fy_d    = tbl_fy_q;
        tbl_w_d     = tbl_w_q;
        tbl_h_d     = tbl_h_q;
        if (elem_we) begin
            tbl_valid_d[elem_idx] = elem_valid;
            tbl_sx_d[elem_idx]    = elem_sprite_x;
            tbl_sy_d[elem_idx]    = elem_sprite_y;
            tbl_fx_d[elem_idx]    = elem_frame_x;
            tbl_fy_d[elem_idx]    = elem_frame_y;
            tbl_w_d[elem_idx]     = elem_width;
            tbl_h_d[elem_idx]     = elem_height;
        end
    end

    always_ff @(posedge clk_33m) begin
        if (rst) begin
            tbl_valid_q <= '0;
        end else begin
            tbl_valid_q <= tbl_valid_d;
        end
    end

    always_ff @(posedge clk_33m) begin
        tbl_sx_q <= tbl_sx_d;
        tbl_sy_q <= tbl_sy_d;
        tbl_fx_q <= tbl_fx_d;
        tbl_fy_q <= tbl_fy_d;
        tbl_w_q  <= tbl_w_d;
        tbl_h_q  <= tbl_h_d;
    end

    // Sequencer next-state logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        fill_d  = fill_q;
        psx_d   = psx_q;
        psy_d   = psy_q;
        pfx_d   = pfx_q;
        pfy_d   = pfy_q;
        pw_d    = pw_q;
        ph_d    = ph_q;
`ifdef PAINT_SCHEDULER_CLEAR_EN
        clr_x_d = clr_x_q;
        clr_y_d = clr_y_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
`ifdef PAINT_SCHEDULER_CLEAR_EN
                    state_d = ST_CLEAR;
                    clr_x_d = '0;
                    clr_y_d = '0;
`else
                    state_d = ST_SCAN;
                    idx_d   = '0;
`endif
                end
            end
`ifdef PAINT_SCHEDULER_CLEAR_EN
            ST_CLEAR: begin
                if (clr_x_q == LAST_X) begin
                    clr_x_d = '0;
                    if (clr_y_q == LAST_Y) begin
                        state_d = ST_SCAN;
                        idx_d   = '0;
                    end else begin
                        clr_y_d = clr_y_q + COOR_WIDTH'(1);
                    end
                end else begin
                    clr_x_d = clr_x_q + COOR_WIDTH'(1);
                end
            end
`endif
            ST_SCAN: begin
                if (tbl_valid_q[idx_q] && (tbl_w_q[idx_q] != '0) && (tbl_h_q[idx_q] != '0)) begin
                    psx_d   = tbl_sx_q[idx_q];
                    psy_d   = tbl_sy_q[idx_q];
                    pfx_d   = tbl_fx_q[idx_q];
                    pfy_d   = tbl_fy_q[idx_q];
                    pw_d    = tbl_w_q[idx_q];
                    ph_d    = tbl_h_q[idx_q];
                    state_d = ST_ISSUE;
                end else if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                fill_d  = 2'd2;
            end
            ST_WAIT: begin
                // The first two WAIT cycles cover paint_element's pipeline fill.
                if (fill_q != 2'd0) begin
                    fill_d = fill_q - 2'd1;
                end else if (paint_finished) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_SCAN;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_33m) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            fill_q  <= '0;
            psx_q   <= '0;
            psy_q   <= '0;
            pfx_q   <= '0;
            pfy_q   <= '0;
            pw_q    <= '0;
            ph_q    <= '0;
`ifdef PAINT_SCHEDULER_CLEAR_EN
            clr_x_q <= '0;
            clr_y_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            fill_q  <= fill_d;
            psx_q   <= psx_d;
            psy_q   <= psy_d;
            pfx_q   <= pfx_d;
            pfy_q   <= pfy_d;
            pw_q    <= pw_d;
            ph_q    <= ph_d;
`ifdef PAINT_SCHEDULER_CLEAR_EN
            clr_x_q <= clr_x_d;
            clr_y_q <= clr_y_d;
`endif
        end
    end

    assign paint_sprite_x = psx_q;
    assign paint_sprite_y = psy_q;
    assign paint_frame_x  = pfx_q;
    assign paint_frame_y  = pfy_q;
    assign paint_width    = pw_q;
    assign paint_height   = ph_q;

    // Outputs decode from registered state only, except the WAIT pixel path,
    // which passes paint_element's stream straight through so that the last
    // pixel (presented together with paint_finished) lands in WAIT.
    always_comb begin
        busy        = (state_q != ST_IDLE);
        frame_done  = (state_q == ST_DONE);
        paint_rst   = (state_q == ST_ISSUE);
        out_we      = 1'b0;
        out_x       = '0;
        out_y       = '0;
        out_palette = 3'd0;
        case (state_q)
`ifdef PAINT_SCHEDULER_CLEAR_EN
            ST_CLEAR: begin
                out_we      = 1'b1;
                out_x       = clr_x_q;
                out_y       = clr_y_q;
                out_palette = CLEAR_PALETTE;
            end
`endif
            ST_WAIT: begin
                if (fill_q == 2'd0) begin
                    out_we      = (paint_write_palette != 3'd0);
                    out_x       = paint_write_x;
                    out_y       = paint_write_y;
                    out_palette = paint_write_palette;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_paint_scheduler.sv
module tb_paint_scheduler;

    localparam int CW = 12;
    localparam int FW = 8;
    localparam int FH = 4;
`ifdef PAINT_SCHEDULER_CLEAR_EN
    localparam int CLR_CYC = FW * FH;
`else
    localparam int CLR_CYC = 0;
`endif

    logic clk_33m = 1'b0;
    logic rst, frame_start, busy, frame_done;
    logic elem_we, elem_valid;
    logic [3:0] elem_idx;
    logic [CW-1:0] elem_sprite_x, elem_sprite_y, elem_width, elem_height;
    logic signed [CW-1:0] elem_frame_x, elem_frame_y;
    logic paint_rst, paint_finished;
    logic [CW-1:0] paint_sprite_x, paint_sprite_y, paint_width, paint_height;
    logic signed [CW-1:0] paint_frame_x, paint_frame_y;
    logic [CW-1:0] paint_write_x, paint_write_y;
    logic [2:0] paint_write_palette;
    logic out_we;
    logic [CW-1:0] out_x, out_y;
    logic [2:0] out_palette;

    paint_scheduler #(.COOR_WIDTH(CW), .MAX_ELEMENTS(16), .FRAME_WIDTH(FW),
                      .FRAME_HEIGHT(FH), .CLEAR_PALETTE(3'd1)) dut (
        .clk_33m(clk_33m), .rst(rst), .frame_start(frame_start), .busy(busy),
        .frame_done(frame_done), .elem_we(elem_we), .elem_idx(elem_idx),
        .elem_valid(elem_valid), .elem_sprite_x(elem_sprite_x),
        .elem_sprite_y(elem_sprite_y), .elem_frame_x(elem_frame_x),
        .elem_frame_y(elem_frame_y), .elem_width(elem_width),
        .elem_height(elem_height), .paint_rst(paint_rst),
        .paint_sprite_x(paint_sprite_x), .paint_sprite_y(paint_sprite_y),
        .paint_frame_x(paint_frame_x), .paint_frame_y(paint_frame_y),
        .paint_width(paint_width), .paint_height(paint_height),
        .paint_finished(paint_finished), .paint_write_x(paint_write_x),
        .paint_write_y(paint_write_y), .paint_write_palette(paint_write_palette),
        .out_we(out_we), .out_x(out_x), .out_y(out_y), .out_palette(out_palette)
    );

    always #5 clk_33m = ~clk_33m;

    int n_cmp = 0;
    int n_bad = 0;
    logic [26:0] exp_wr[$];
    logic [71:0] exp_el[$];
    bit m_alt = 1'b0;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] req);
        n_cmp++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, got, req);
        end
    endtask

    // Palette the paint_element model emits for pixel p of an element.
    function automatic logic [2:0] model_pal(input int p);
        if (m_alt && (p % 2 == 1)) return 3'd0;
        return 3'((p % 7) + 1);
    endfunction

    // paint_element model: 2 cycles of pipeline fill after the start pulse,
    // then one pixel per cycle row-major; finished accompanies the last pixel.
    initial begin : pe_model
        int act, dly, pix, w, h;
        act = 0; dly = 0; pix = 0;
        paint_finished = 1'b0; paint_write_x = '0; paint_write_y = '0;
        paint_write_palette = 3'd0;
        forever begin
            @(negedge clk_33m);
            paint_finished = 1'b0; paint_write_x = '0; paint_write_y = '0;
            paint_write_palette = 3'd0;
            if (!busy) begin
                act = 0;
            end else if (paint_rst) begin
                act = 1; dly = 2; pix = 0;
            end else if (act != 0 && dly > 0) begin
                dly--;
            end else if (act != 0) begin
                w = int'(paint_width);
                h = int'(paint_height);
                if (w == 0) w = 1;
                paint_write_x = paint_frame_x + CW'(pix % w);
                paint_write_y = paint_frame_y + CW'(pix / w);
                paint_write_palette = model_pal(pix);
                if (pix >= w * h - 1) begin
                    paint_finished = 1'b1;
                    act = 0;
                end
                pix++;
            end
        end
    end

    // Monitor: pops an expectation whenever the DUT writes or starts paint.
    initial begin : monitor
        logic [26:0] ew;
        logic [71:0] ee;
        forever begin
            @(negedge clk_33m);
            #1;
            if (out_we) begin
                if (exp_wr.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_write: got x=%0d y=%0d pal=%0d, required no write",
                             out_x, out_y, out_palette);
                end else begin
                    ew = exp_wr.pop_front();
                    chk("write_xy_pal", {out_x, out_y, out_palette}, ew);
                end
            end
            if (paint_rst) begin
                if (exp_el.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_paint_rst: got w=%0d h=%0d, required no start",
                             paint_width, paint_height);
                end else begin
                    ee = exp_el.pop_front();
                    chk("paint_params", {paint_sprite_x, paint_sprite_y, paint_frame_x,
                                         paint_frame_y, paint_width, paint_height}, ee);
                end
            end
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic write_elem(input int idx, input bit v, input int sx, input int sy,
                              input int fx, input int fy, input int w, input int h);
        elem_we = 1'b1; elem_idx = 4'(idx); elem_valid = v;
        elem_sprite_x = CW'(sx); elem_sprite_y = CW'(sy);
        elem_frame_x = CW'(fx); elem_frame_y = CW'(fy);
        elem_width = CW'(w); elem_height = CW'(h);
        @(negedge clk_33m);
        elem_we = 1'b0;
    endtask

    task automatic push_clear();
`ifdef PAINT_SCHEDULER_CLEAR_EN
        for (int y = 0; y < FH; y++)
            for (int x = 0; x < FW; x++)
                exp_wr.push_back({CW'(x), CW'(y), 3'd1});
`endif
    endtask

    task automatic push_elem(input int sx, input int sy, input int fx, input int fy,
                             input int w, input int h);
        logic [2:0] pal;
        exp_el.push_back({CW'(sx), CW'(sy), CW'(fx), CW'(fy), CW'(w), CW'(h)});
        for (int p = 0; p < w * h; p++) begin
            pal = model_pal(p);
            if (pal != 3'd0)
                exp_wr.push_back({CW'(fx + p % w), CW'(fy + p / w), pal});
        end
    endtask

    // Issues frame_start in cycle 0 and counts cycles until frame_done.
    task automatic run_frame(input string nm, input int exp_cyc, input bit poke_done);
        int n;
        bit seen;
        frame_start = 1'b1;
        n = 0; seen = 0;
        while (!seen && n < 2000) begin
            @(negedge clk_33m);
            frame_start = 1'b0;
            n++;
            if (n == 1) chk({nm, "_busy_c1"}, busy, 1'b1);
            if (frame_done) seen = 1;
        end
        chk({nm, "_done_cycle"}, n, seen ? exp_cyc : -1);
        if (poke_done) frame_start = 1'b1;
        @(negedge clk_33m);
        frame_start = 1'b0;
        chk({nm, "_busy_after"}, busy, 1'b0);
        if (poke_done) begin
            @(negedge clk_33m);
            chk({nm, "_start_on_done_ignored"}, busy, 1'b0);
        end
        chk({nm, "_wr_drained"}, exp_wr.size(), 0);
        chk({nm, "_el_drained"}, exp_el.size(), 0);
    endtask

    initial begin : stim
        int n;
        rst = 1'b1; frame_start = 1'b0; elem_we = 1'b0; elem_idx = '0; elem_valid = 1'b0;
        elem_sprite_x = '0; elem_sprite_y = '0; elem_frame_x = '0; elem_frame_y = '0;
        elem_width = '0; elem_height = '0;
        repeat (3) @(negedge clk_33m);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", frame_done, 1'b0);
        chk("rst_out_we", out_we, 1'b0);
        chk("rst_paint_rst", paint_rst, 1'b0);
        chk("rst_paint_regs", {paint_sprite_x, paint_frame_x, paint_width, paint_height}, 48'd0);
        rst = 1'b0;
        @(negedge clk_33m);

        // Empty table: clear pass (when built in) then 16 SCAN cycles.
        push_clear();
        run_frame("empty", CLR_CYC + 17, 1'b0);

        // Single element at idx 3.
        write_elem(3, 1, 10, 0, 5, 2, 4, 2);
        push_clear();
        push_elem(10, 0, 5, 2, 4, 2);
        run_frame("single", CLR_CYC + 17 + 3 + 8, 1'b0);

        // Skip rules; also frame_start coinciding with frame_done.
        write_elem(3, 0, 0, 0, 0, 0, 0, 0);
        write_elem(0, 0, 1, 1, 1, 1, 4, 2);
        write_elem(1, 1, 2, 2, 2, 2, 0, 3);
        write_elem(2, 1, 7, 8, 20, 30, 3, 1);
        push_clear();
        push_elem(7, 8, 20, 30, 3, 1);
        run_frame("skip", CLR_CYC + 17 + 3 + 3, 1'b1);

        // Transparency with a negative frame origin.
        write_elem(1, 0, 0, 0, 0, 0, 0, 0);
        write_elem(2, 0, 0, 0, 0, 0, 0, 0);
        write_elem(7, 1, 100, 200, -2, -1, 3, 2);
        m_alt = 1'b1;
        push_clear();
        push_elem(100, 200, -2, -1, 3, 2);
        run_frame("transp", CLR_CYC + 17 + 3 + 6, 1'b0);
        m_alt = 1'b0;
        write_elem(7, 0, 0, 0, 0, 0, 0, 0);

        // Table writes during a frame.
        write_elem(0, 1, 1, 2, 3, 4, 2, 2);
        write_elem(5, 1, 9, 9, 9, 9, 1, 1);
        push_clear();
        push_elem(1, 2, 3, 4, 2, 2);
        push_elem(11, 12, 40, 41, 3, 2);
        fork
            run_frame("wr_during", CLR_CYC + 17 + 7 + 9, 1'b0);
            begin
                n = 0;
                while (!paint_rst && n < 500) begin
                    @(negedge clk_33m);
                    n++;
                end
                chk("wr_during_found_issue", paint_rst, 1'b1);
                @(negedge clk_33m);
                write_elem(0, 1, 50, 50, 50, 50, 5, 5);
                write_elem(5, 1, 11, 12, 40, 41, 3, 2);
            end
        join
        write_elem(0, 0, 0, 0, 0, 0, 0, 0);

        // Reset while in WAIT; frame_start while busy is ignored.
        write_elem(2, 1, 0, 0, 0, 0, 2, 2);
        push_clear();
        exp_el.push_back({CW'(0), CW'(0), CW'(0), CW'(0), CW'(2), CW'(2)});
        frame_start = 1'b1;
        @(negedge clk_33m);
        frame_start = 1'b0;
        n = 0;
        while (!paint_rst && n < 500) begin
            @(negedge clk_33m);
            n++;
        end
        chk("rst_test_found_issue", paint_rst, 1'b1);
        frame_start = 1'b1;
        @(negedge clk_33m);
        frame_start = 1'b0;
        rst = 1'b1;
        @(negedge clk_33m);
        rst = 1'b0;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_out_we", out_we, 1'b0);
        chk("midrst_paint_rst", paint_rst, 1'b0);
        chk("midrst_done", frame_done, 1'b0);
        chk("midrst_paint_regs", {paint_sprite_x, paint_frame_x, paint_width, paint_height}, 48'd0);
        @(negedge clk_33m);
        chk("midrst_stays_idle", busy, 1'b0);
        push_clear();
        run_frame("after_rst", CLR_CYC + 17, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
